// File: rtl/ym_bus_sequencer.sv
// AY/YM PSG bus sequencer: queued address/data writes with SETUP/STROBE/HOLD timing
// on BDIR/BC1/DA, plus in-band chip-select commands consumed between operations.
module ym_bus_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_kind,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] da,
  output logic       da_oe,
  output logic       ym_0,
  output logic       ym_1,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);

  typedef struct packed {
    logic       kind;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  entry_t        fifo_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          ready_en_q;
  logic          empty, full, push, pop;
  entry_t        head;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          kind_q, kind_d;
  logic [7:0]    da_q, da_d;
  logic          ym0_q, ym0_d;
  logic          bdir_q, bdir_d, bc1_q, bc1_d, oe_q, oe_d;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // ready_en_q holds req_ready low until the first edge after reset release
  assign req_ready = ready_en_q && !full;
  assign push      = req_valid && req_ready;
  assign head      = fifo_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= '{kind: req_kind, data: req_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kind_q  <= 1'b0;
      da_q    <= '0;
      ym0_q   <= 1'b0;
      bdir_q  <= 1'b0;
      bc1_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      da_q    <= da_d;
      ym0_q   <= ym0_d;
      bdir_q  <= bdir_d;
      bc1_q   <= bc1_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    da_d    = da_q;
    ym0_d   = ym0_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        // chip-select commands never reach the AY bus
        if (!head.kind && head.data[7:3] == 5'b11111) begin
          ym0_d = head.data[0];
        end else begin
          kind_d  = head.kind;
          da_d    = head.data;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: if (cnt_q == 4'd0) begin
        state_d = STROBE;
        cnt_d   = STROBE_LD;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      STROBE: if (cnt_q == 4'd0) begin
        state_d = HOLD;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // bus pins are registered copies of the next state's levels
    bdir_d = (state_d == STROBE);
    bc1_d  = (state_d == STROBE) && !kind_d;
    oe_d   = (state_d != IDLE);
  end

  assign bdir  = bdir_q;
  assign bc1   = bc1_q;
  assign da    = da_q;
  assign da_oe = oe_q;
  assign ym_0  = ym0_q;
  assign ym_1  = !ym0_q;
  assign busy  = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_ym_bus_sequencer.sv
// Scoreboard bench: two sequencer instances (default timing and 3/15 timing); stimulus
// queues expected bus events, a negedge monitor pops and checks them as the bus moves.
module tb_ym_bus_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]      rv, rk, rr, bd, b1, oe, y0, y1, bs;
  logic [1:0][7:0] rdat, da;

  ym_bus_sequencer u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_kind(rk[0]), .req_data(rdat[0]),
    .req_ready(rr[0]), .bdir(bd[0]), .bc1(b1[0]), .da(da[0]), .da_oe(oe[0]),
    .ym_0(y0[0]), .ym_1(y1[0]), .busy(bs[0]));

  ym_bus_sequencer #(.SETUP_CYC(3), .STROBE_CYC(15), .DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_kind(rk[1]), .req_data(rdat[1]),
    .req_ready(rr[1]), .bdir(bd[1]), .bc1(b1[1]), .da(da[1]), .da_oe(oe[1]),
    .ym_0(y0[1]), .ym_1(y1[1]), .busy(bs[1]));

  typedef struct packed {
    logic       sel;
    logic       kind;
    logic [7:0] data;
    logic [3:0] gap;   // required idle clocks before this op, 0 = unchecked
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_vec = 0, n_bad = 0;
  logic [1:0] ymm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int setc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int stbc(input int d);
    return (d == 0) ? 4 : 15;
  endfunction

  // ---------------- monitor ----------------
  int         phase[2], scnt[2], tcnt[2], gap[2], gap_seen[2];
  logic [7:0] dref[2];
  logic       uns[2], kref[2], prev_ym[2];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          phase[d] = 0; gap[d] = 0; uns[d] = 1'b0; prev_ym[d] = 1'b0;
        end else begin
          if (y0[d] != prev_ym[d]) begin
            if (qsz(d) == 0) chk("ym_unexpected", 1, 0);
            else begin
              e = qpop(d);
              chk("ym_is_select", e.sel, 1);
              chk("ym_value", y0[d], e.data[0]);
              chk("ym_in_idle", phase[d], 0);
              chk("ym1_inverse", y1[d], !y0[d]);
            end
            prev_ym[d] = y0[d];
          end
          case (phase[d])
            0: begin
              if (oe[d] && !bd[d]) begin
                phase[d] = 1; scnt[d] = 1; dref[d] = da[d]; uns[d] = 1'b0; gap_seen[d] = gap[d];
              end else if (oe[d] || bd[d]) begin
                chk("strobe_without_setup", 1, 0);
              end else begin
                gap[d]++;
              end
            end
            1: begin
              if (oe[d] && !bd[d]) begin
                scnt[d]++;
                if (da[d] != dref[d]) uns[d] = 1'b1;
              end else if (bd[d]) begin
                if (qsz(d) == 0) begin
                  chk("strobe_unexpected", 1, 0);
                  e = '0;
                end else begin
                  e = qpop(d);
                  chk("strobe_not_select", e.sel, 0);
                  chk("strobe_bc1", b1[d], !e.kind);
                  chk("strobe_da", da[d], e.data);
                  chk("setup_len", scnt[d], setc(d));
                  if (e.gap != 0) chk("idle_gap", gap_seen[d], e.gap);
                end
                if (da[d] != dref[d] || !oe[d]) uns[d] = 1'b1;
                kref[d] = b1[d]; phase[d] = 2; tcnt[d] = 1;
              end else begin
                chk("setup_abort", 1, 0);
                phase[d] = 0;
              end
            end
            2: begin
              if (bd[d]) begin
                tcnt[d]++;
                if (da[d] != dref[d] || b1[d] != kref[d] || !oe[d]) uns[d] = 1'b1;
              end else begin
                chk("strobe_len", tcnt[d], stbc(d));
                chk("hold_oe", oe[d], 1);
                chk("hold_bc1", b1[d], 0);
                chk("hold_da", da[d], dref[d]);
                chk("da_stable", uns[d], 0);
                phase[d] = 3;
              end
            end
            default: begin
              chk("idle_oe", oe[d], 0);
              chk("idle_da_kept", da[d], dref[d]);
              phase[d] = 0; gap[d] = 1;
            end
          endcase
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int d, input logic k, input logic [7:0] v, input int g,
                      output int stalls);
    exp_t e;
    @(negedge clk);
    rv[d] = 1'b1; rk[d] = k; rdat[d] = v; stalls = 0;
    while (!rr[d] && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (!rr[d]) begin
      chk("push_timeout", 0, 1);
      rv[d] = 1'b0;
      return;
    end
    e = '0;
    if (!k && v[7:3] == 5'b11111) begin
      if (v[0] != ymm[d]) begin
        e.sel = 1'b1; e.data = v; ymm[d] = v[0];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end else begin
      e.kind = k; e.data = v; e.gap = 4'(g);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1 rv[d] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bs != 2'b00) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", bs, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bdir(input int d);
    int n = 0;
    while (!bd[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bdir_seen", bd[d], 1);
  endtask

  initial begin
    int s;
    rv = '0; rk = '0; rdat = '0; ymm = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bdir", bd[0], 0);
    chk("rst_bc1", b1[0], 0);
    chk("rst_da", da[0], 8'h00);
    chk("rst_da_oe", oe[0], 0);
    chk("rst_ym0", y0[0], 0);
    chk("rst_ym1", y1[0], 1);
    chk("rst_busy", bs[0], 0);
    chk("rst_ready", rr, 2'b00);
    reset = 1'b1;
    #1 chk("ready_before_edge", rr[0], 0);
    @(posedge clk);
    #1 chk("ready_first_edge", rr, 2'b11);

    // address latch then data write, back to back
    push(0, 1'b0, 8'h07, 0, s);
    push(0, 1'b1, 8'h38, 1, s);
    wait_idle();

    // chip selects: FE leaves ym_0 at 0, FF raises it
    push(0, 1'b0, 8'hFE, 0, s);
    push(0, 1'b0, 8'hFF, 0, s);
    wait_idle();
    chk("cs_ym0", y0[0], 1);
    chk("cs_ym1", y1[0], 0);

    // fill the queue behind a running op; fifth push must stall
    push(0, 1'b1, 8'hAA, 0, s);
    wait_bdir(0);
    push(0, 1'b0, 8'h01, 1, s);
    push(0, 1'b1, 8'h02, 1, s);
    push(0, 1'b0, 8'h03, 1, s);
    push(0, 1'b1, 8'h04, 1, s);
    chk("fourth_no_stall", s, 0);
    push(0, 1'b1, 8'h05, 1, s);
    chk("full_stall", (s > 0), 1);
    wait_idle();

    // select queued behind a write changes ym_0 only after HOLD
    push(0, 1'b0, 8'hFE, 0, s);
    wait_idle();
    push(0, 1'b1, 8'h5A, 0, s);
    push(0, 1'b0, 8'hFF, 0, s);
    wait_idle();
    chk("cs_after_write", y0[0], 1);

    // reset during the second STROBE clock with two entries queued
    push(0, 1'b1, 8'h11, 0, s);
    push(0, 1'b0, 8'h22, 1, s);
    push(0, 1'b1, 8'h33, 1, s);
    wait_bdir(0);
    @(posedge clk);
    #2 reset = 1'b0;
    q0.delete(); q1.delete(); ymm = '0;
    #1 chk("async_bdir", bd[0], 0);
    chk("async_bc1", b1[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_busy", bs[0], 0);
    chk("post_rst_ym0", y0[0], 0);
    repeat (20) @(negedge clk);
    chk("post_rst_still_idle", bs[0], 0);

    // long timing on the second instance
    push(1, 1'b1, 8'hC3, 0, s);
    push(1, 1'b0, 8'h3C, 1, s);
    wait_idle();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end
endmodule
